// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester port bundle for the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 12
);
  logic                  req;
  logic                  we;
  logic [ADD_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, output we, output addr, output wdata, input ack, input rdata);
  modport slave  (input req, input we, input addr, input wdata, output ack, output rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin two-port arbiter for the shared instruction/data memory
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 12,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mem_port_arbiter_if.slave     p0,
  mem_port_arbiter_if.slave     p1,
  output logic                  busy,
  output logic                  m_ren,
  output logic [ADD_WIDTH-1:0]  m_rd_address,
  output logic                  m_wen,
  output logic [ADD_WIDTH-1:0]  m_wr_address,
  output logic [DATA_WIDTH-1:0] m_data_out,
  input  logic [DATA_WIDTH-1:0] m_data_in
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;

  generate
    if (MEM_LAT < 1) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state;
  logic                  rr;      // port favoured on the next contended grant
  logic                  id;      // port owning the transaction in flight
  logic                  we_r;
  logic [CNT_W-1:0]      cnt;

  logic                  pick1;
  logic                  win_we;
  logic [ADD_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // Grant selection: a lone requester wins, on contention the rr pointer decides.
  always_comb begin
    pick1     = p1.req && (!p0.req || rr);
    win_we    = pick1 ? p1.we    : p0.we;
    win_addr  = pick1 ? p1.addr  : p0.addr;
    win_wdata = pick1 ? p1.wdata : p0.wdata;
  end

  // Transaction sequencer; strobes, acks and rdata are registered pulses and the
  // memory address/data outputs double as the latched request fields.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr           <= 1'b0;
      id           <= 1'b0;
      we_r         <= 1'b0;
      cnt          <= '0;
      busy         <= 1'b0;
      m_ren        <= 1'b0;
      m_wen        <= 1'b0;
      m_rd_address <= '0;
      m_wr_address <= '0;
      m_data_out   <= '0;
      p0.ack       <= 1'b0;
      p1.ack       <= 1'b0;
      p0.rdata     <= '0;
      p1.rdata     <= '0;
    end else begin
      m_ren    <= 1'b0;
      m_wen    <= 1'b0;
      p0.ack   <= 1'b0;
      p1.ack   <= 1'b0;
      p0.rdata <= '0;
      p1.rdata <= '0;
      case (state)
        IDLE: begin
          if (p0.req || p1.req) begin
            id    <= pick1;
            we_r  <= win_we;
            busy  <= 1'b1;
            state <= ISSUE;
            if (win_we) begin
              m_wen        <= 1'b1;
              m_wr_address <= win_addr;
              m_data_out   <= win_wdata;
            end else begin
              m_ren        <= 1'b1;
              m_rd_address <= win_addr;
            end
          end
        end
        ISSUE: begin
          if (we_r) begin
            state <= RESP;
            if (id) p1.ack <= 1'b1;
            else    p0.ack <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            if (id) begin
              p1.ack   <= 1'b1;
              p1.rdata <= m_data_in;
            end else begin
              p0.ack   <= 1'b1;
              p0.rdata <= m_data_in;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          rr    <= ~id;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          at;
  } ack_t;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    int          at;
  } stb_t;

  logic clock = 1'b0;
  logic reset_n;
  int   cyc = 0;
  bit   done = 1'b0;

  always #5 clock = ~clock;

  // cycle index; stimulus and monitor both read it after it settles
  always @(posedge clock) cyc <= cyc + 1;

  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADD_WIDTH(12)) a0 ();
  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADD_WIDTH(12)) a1 ();
  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADD_WIDTH(12)) b0 ();
  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADD_WIDTH(12)) b1 ();

  logic        busy0, m_ren0, m_wen0;
  logic [11:0] m_rd_addr0, m_wr_addr0;
  logic [31:0] m_dout0, m_din0;
  logic        busy1, m_ren1, m_wen1;
  logic [11:0] m_rd_addr1, m_wr_addr1;
  logic [31:0] m_dout1, m_din1;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADD_WIDTH(12), .MEM_LAT(1)) u0 (
    .clock(clock), .reset_n(reset_n), .p0(a0), .p1(a1), .busy(busy0),
    .m_ren(m_ren0), .m_rd_address(m_rd_addr0), .m_wen(m_wen0),
    .m_wr_address(m_wr_addr0), .m_data_out(m_dout0), .m_data_in(m_din0)
  );

  mem_port_arbiter #(.DATA_WIDTH(32), .ADD_WIDTH(12), .MEM_LAT(3)) u1 (
    .clock(clock), .reset_n(reset_n), .p0(b0), .p1(b1), .busy(busy1),
    .m_ren(m_ren1), .m_rd_address(m_rd_addr1), .m_wen(m_wen1),
    .m_wr_address(m_wr_addr1), .m_data_out(m_dout1), .m_data_in(m_din1)
  );

  // memory models: unwritten words read as init_word(); data valid only in the latency slot
  logic [31:0] mem0 [4096];
  bit          vld0 [4096];
  logic [31:0] mem1 [4096];
  bit          vld1 [4096];
  logic [31:0] rd0 = 32'h0;
  logic [31:0] s0 = 32'h0, s1 = 32'h0, s2 = 32'h0;

  function automatic logic [31:0] init_word(input logic [11:0] a);
    return (a == 12'h010) ? 32'hDEADBEEF : {20'hC0DE0, a};
  endfunction

  always @(posedge clock) begin
    if (m_wen0) begin
      mem0[m_wr_addr0] <= m_dout0;
      vld0[m_wr_addr0] <= 1'b1;
    end
    rd0 <= m_ren0 ? (vld0[m_rd_addr0] ? mem0[m_rd_addr0] : init_word(m_rd_addr0)) : 32'h0;
    if (m_wen1) begin
      mem1[m_wr_addr1] <= m_dout1;
      vld1[m_wr_addr1] <= 1'b1;
    end
    s0 <= m_ren1 ? (vld1[m_rd_addr1] ? mem1[m_rd_addr1] : init_word(m_rd_addr1)) : 32'h0;
    s1 <= s0;
    s2 <= s1;
  end

  assign m_din0 = rd0;
  assign m_din1 = s2;

  ack_t aq0[$];
  ack_t aq1[$];
  stb_t sq0[$];

  function automatic void exp_ack0(input int port, input logic [31:0] d, input int at);
    ack_t e;
    e.port = port; e.data = d; e.at = at;
    aq0.push_back(e);
  endfunction

  function automatic void exp_ack1(input int port, input logic [31:0] d, input int at);
    ack_t e;
    e.port = port; e.data = d; e.at = at;
    aq1.push_back(e);
  endfunction

  function automatic void exp_stb0(input logic we, input logic [11:0] addr, input logic [31:0] d, input int at);
    stb_t e;
    e.we = we; e.addr = addr; e.data = d; e.at = at;
    sq0.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // stimulus: directed vectors, expectations pushed as each request is issued
  initial begin
    int n;
    reset_n = 1'b0;
    a0.req = 1'b0; a0.we = 1'b0; a0.addr = '0; a0.wdata = '0;
    a1.req = 1'b0; a1.we = 1'b0; a1.addr = '0; a1.wdata = '0;
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;
    b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // single read from port 0
    n = cyc;
    a0.we = 1'b0; a0.addr = 12'h010; a0.req = 1'b1;
    exp_stb0(1'b0, 12'h010, 32'h0, n + 1);
    exp_ack0(0, 32'hDEADBEEF, n + 3);
    tick(4);
    a0.req = 1'b0;
    tick(1);

    // port 1 write then back-to-back read of the same word
    n = cyc;
    a1.we = 1'b1; a1.addr = 12'h0A5; a1.wdata = 32'h12345678; a1.req = 1'b1;
    exp_stb0(1'b1, 12'h0A5, 32'h12345678, n + 1);
    exp_ack0(1, 32'h0, n + 2);
    tick(3);
    a1.we = 1'b0;
    exp_stb0(1'b0, 12'h0A5, 32'h0, n + 4);
    exp_ack0(1, 32'h12345678, n + 6);
    tick(4);
    a1.req = 1'b0;
    tick(1);

    // request fields changing after the grant must not leak into the transaction
    n = cyc;
    a0.we = 1'b1; a0.addr = 12'h100; a0.wdata = 32'hA5A5A5A5; a0.req = 1'b1;
    exp_stb0(1'b1, 12'h100, 32'hA5A5A5A5, n + 1);
    exp_ack0(0, 32'h0, n + 2);
    tick(1);
    a0.we = 1'b0; a0.addr = 12'h1FF; a0.wdata = 32'hFFFF0000;
    tick(2);
    a0.req = 1'b0;
    tick(1);
    n = cyc;
    a1.we = 1'b0; a1.addr = 12'h100; a1.req = 1'b1;
    exp_stb0(1'b0, 12'h100, 32'h0, n + 1);
    exp_ack0(1, 32'hA5A5A5A5, n + 3);
    tick(4);
    a1.req = 1'b0;
    tick(1);

    // reset during WAIT drops the read; the held request is re-served afterwards
    n = cyc;
    a0.we = 1'b0; a0.addr = 12'h020; a0.req = 1'b1;
    exp_stb0(1'b0, 12'h020, 32'h0, n + 1);
    tick(2);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    exp_stb0(1'b0, 12'h020, 32'h0, n + 5);
    exp_ack0(0, 32'hC0DE0020, n + 7);
    tick(4);
    a0.req = 1'b0;
    tick(1);

    // contention straight after reset: grants alternate 0,1,0,1
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    n = cyc;
    a0.we = 1'b0; a0.addr = 12'h030; a0.req = 1'b1;
    a1.we = 1'b0; a1.addr = 12'h040; a1.req = 1'b1;
    exp_stb0(1'b0, 12'h030, 32'h0, n + 1);
    exp_stb0(1'b0, 12'h040, 32'h0, n + 5);
    exp_stb0(1'b0, 12'h031, 32'h0, n + 9);
    exp_stb0(1'b0, 12'h041, 32'h0, n + 13);
    exp_ack0(0, 32'hC0DE0030, n + 3);
    exp_ack0(1, 32'hC0DE0040, n + 7);
    exp_ack0(0, 32'hC0DE0031, n + 11);
    exp_ack0(1, 32'hC0DE0041, n + 15);
    tick(4);
    a0.addr = 12'h031;
    tick(4);
    a1.addr = 12'h041;
    tick(4);
    a0.req = 1'b0;
    tick(4);
    a1.req = 1'b0;
    tick(1);

    // three-cycle memory latency instance
    n = cyc;
    b0.we = 1'b0; b0.addr = 12'h010; b0.req = 1'b1;
    exp_ack1(0, 32'hDEADBEEF, n + 5);
    tick(6);
    b0.we = 1'b1; b0.addr = 12'h055; b0.wdata = 32'hCAFEF00D;
    exp_ack1(0, 32'h0, n + 8);
    tick(3);
    b0.we = 1'b0;
    exp_ack1(0, 32'hCAFEF00D, n + 14);
    tick(6);
    b0.req = 1'b0;
    tick(3);
    done = 1'b1;
  end

  // monitor: compares every ack and strobe against the scoreboard, away from the active edge
  initial begin
    int   vecs = 0;
    int   errs = 0;
    bit   pa0 = 0, pa1 = 0, pb0 = 0, pb1 = 0;
    ack_t ea;
    stb_t es;
    int   gp;
    logic [31:0] gd, other;
    logic [11:0] ga;
    while (!done) begin
      @(negedge clock);
      if (!reset_n) begin
        vecs++;
        if ({busy0, m_ren0, m_wen0, m_rd_addr0, m_wr_addr0, m_dout0, a0.ack, a0.rdata, a1.ack, a1.rdata} != '0 ||
            {busy1, m_ren1, m_wen1, m_rd_addr1, m_wr_addr1, m_dout1, b0.ack, b0.rdata, b1.ack, b1.rdata} != '0) begin
          errs++;
          $display("FAIL reset_zero cyc=%0d u0=%h u1=%h required all zero", cyc,
                   {busy0, m_ren0, m_wen0, m_rd_addr0, m_wr_addr0, m_dout0, a0.ack, a0.rdata, a1.ack, a1.rdata},
                   {busy1, m_ren1, m_wen1, m_rd_addr1, m_wr_addr1, m_dout1, b0.ack, b0.rdata, b1.ack, b1.rdata});
        end
        pa0 = 0; pa1 = 0; pb0 = 0; pb1 = 0;
      end else begin
        if ((m_ren0 && m_wen0) || (m_ren1 && m_wen1)) begin
          errs++;
          $display("FAIL strobe_excl cyc=%0d u0 ren/wen=%b%b u1 ren/wen=%b%b required not both", cyc, m_ren0, m_wen0, m_ren1, m_wen1);
        end
        if ((a0.ack && pa0) || (a1.ack && pa1) || (b0.ack && pb0) || (b1.ack && pb1)) begin
          errs++;
          $display("FAIL ack_len cyc=%0d acks=%b%b%b%b required single-cycle pulses", cyc, a0.ack, a1.ack, b0.ack, b1.ack);
        end
        if ((a0.ack && a1.ack) || (b0.ack && b1.ack)) begin
          errs++;
          $display("FAIL ack_both cyc=%0d acks=%b%b%b%b required one port at a time", cyc, a0.ack, a1.ack, b0.ack, b1.ack);
        end
        if ((!a0.ack && a0.rdata != 0) || (!a1.ack && a1.rdata != 0) || (!b0.ack && b0.rdata != 0)) begin
          errs++;
          $display("FAIL rdata_idle cyc=%0d rdata=%h/%h/%h required 0 without ack", cyc, a0.rdata, a1.rdata, b0.rdata);
        end
        if (m_ren0 || m_wen0) begin
          vecs++;
          ga = m_wen0 ? m_wr_addr0 : m_rd_addr0;
          if (sq0.size() == 0) begin
            errs++;
            $display("FAIL strobe0_unexpected cyc=%0d wen=%b addr=%h required no strobe", cyc, m_wen0, ga);
          end else begin
            es = sq0.pop_front();
            if (m_wen0 != es.we || ga != es.addr || (es.we && m_dout0 != es.data) || cyc != es.at || !busy0) begin
              errs++;
              $display("FAIL strobe0 got wen=%b addr=%h data=%h cyc=%0d busy=%b required wen=%b addr=%h data=%h cyc=%0d busy=1",
                       m_wen0, ga, m_dout0, cyc, busy0, es.we, es.addr, es.data, es.at);
            end
          end
        end
        if (a0.ack || a1.ack) begin
          vecs++;
          gp    = a1.ack ? 1 : 0;
          gd    = a1.ack ? a1.rdata : a0.rdata;
          other = a1.ack ? a0.rdata : a1.rdata;
          if (aq0.size() == 0) begin
            errs++;
            $display("FAIL ack0_unexpected cyc=%0d port=%0d data=%h required no ack", cyc, gp, gd);
          end else begin
            ea = aq0.pop_front();
            if (gp != ea.port || gd != ea.data || cyc != ea.at || other != 0) begin
              errs++;
              $display("FAIL ack0 got port=%0d data=%h cyc=%0d other=%h required port=%0d data=%h cyc=%0d other=0",
                       gp, gd, cyc, other, ea.port, ea.data, ea.at);
            end
          end
        end
        if (b0.ack || b1.ack) begin
          vecs++;
          gp = b1.ack ? 1 : 0;
          gd = b1.ack ? b1.rdata : b0.rdata;
          if (aq1.size() == 0) begin
            errs++;
            $display("FAIL ack1_unexpected cyc=%0d port=%0d data=%h required no ack", cyc, gp, gd);
          end else begin
            ea = aq1.pop_front();
            if (gp != ea.port || gd != ea.data || cyc != ea.at) begin
              errs++;
              $display("FAIL ack1 got port=%0d data=%h cyc=%0d required port=%0d data=%h cyc=%0d",
                       gp, gd, cyc, ea.port, ea.data, ea.at);
            end
          end
        end
        pa0 = a0.ack; pa1 = a1.ack; pb0 = b0.ack; pb1 = b1.ack;
      end
    end
    vecs++;
    if (aq0.size() != 0 || aq1.size() != 0 || sq0.size() != 0) begin
      errs++;
      $display("FAIL drain pending ack0=%0d ack1=%0d strobe0=%0d required 0/0/0", aq0.size(), aq1.size(), sq0.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
